// File: rtl/spi_bus_ctrl.sv
// spi_bus_ctrl
// Runs the MITM FSM's chunk commands on a live mode-0 SPI bus. MOSI and MISO
// pass straight through from the raw pins unless a chunk substitutes fake bits.
// Real bits are captured on every sclk rise inside a chunk.
//
// Ports
//   sys_clk, rst                  system clock (>= 8x sclk); async active-high reset
//   ss_in, sclk_in                raw slave select (active low) and SPI clock
//   mosi_in, miso_in              raw data pins from the master and the slave
//   mosi_out, miso_out            data to the slave and the master (pass-through or fake)
//   cmd_next_chunk, cmd_finish    one-cycle command pulses
//   next_chunk_size               bit count of the requested chunk (clamped to BUF_SIZE)
//   fake_*_select, fake_*_data    substitution enables and MSB-first fake bits
//   comm_active, bus_ready        transaction in progress / awaiting a command
//   real_*_data                   captured bits, newest at bit 0
//   chunk_overrun                 sticky: sclk rose while awaiting a command
module spi_bus_ctrl #(
  parameter int BUF_SIZE         = 9,
  parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1),
  parameter int SYNC_STAGES      = 2
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        ss_in,
  input  logic                        sclk_in,
  input  logic                        mosi_in,
  input  logic                        miso_in,
  output logic                        mosi_out,
  output logic                        miso_out,
  input  logic                        cmd_next_chunk,
  input  logic                        cmd_finish,
  input  logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size,
  input  logic                        fake_miso_select,
  input  logic                        fake_mosi_select,
  input  logic [BUF_SIZE-1:0]         fake_miso_data,
  input  logic [BUF_SIZE-1:0]         fake_mosi_data,
  output logic                        comm_active,
  output logic                        bus_ready,
  output logic [BUF_SIZE-1:0]         real_miso_data,
  output logic [BUF_SIZE-1:0]         real_mosi_data,
  output logic                        chunk_overrun
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_CHUNK  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [CHUNK_SIZE_WIDTH-1:0] MAX_SIZE = CHUNK_SIZE_WIDTH'(BUF_SIZE);

  // Synchronizers; index SYNC_STAGES-1 is the usable copy
  logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q, miso_sync_q;
  logic                   sclk_prev_q;
  logic                   ss_s, sclk_s, mosi_s, miso_s, sclk_rise, sclk_fall;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      miso_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      ss_sync_q[0]   <= ss_in;
      sclk_sync_q[0] <= sclk_in;
      mosi_sync_q[0] <= mosi_in;
      miso_sync_q[0] <= miso_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        ss_sync_q[i]   <= ss_sync_q[i-1];
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
        miso_sync_q[i] <= miso_sync_q[i-1];
      end
      sclk_prev_q <= sclk_s;
    end
  end

  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign miso_s    = miso_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  logic [1:0]                  state_q, state_d;
  logic                        sel_miso_q, sel_miso_d, sel_mosi_q, sel_mosi_d;
  logic [BUF_SIZE-1:0]         wbuf_miso_q, wbuf_miso_d, wbuf_mosi_q, wbuf_mosi_d;
  logic [BUF_SIZE-1:0]         rbuf_miso_q, rbuf_miso_d, rbuf_mosi_q, rbuf_mosi_d;
  logic [CHUNK_SIZE_WIDTH-1:0] cnt_q, cnt_d, size_q, size_d, cnt_inc;
  logic                        overrun_q, overrun_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    sel_miso_d  = sel_miso_q;
    sel_mosi_d  = sel_mosi_q;
    wbuf_miso_d = wbuf_miso_q;
    wbuf_mosi_d = wbuf_mosi_q;
    rbuf_miso_d = rbuf_miso_q;
    rbuf_mosi_d = rbuf_mosi_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    overrun_d   = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (!ss_s) begin
          state_d   = S_WAIT;
          overrun_d = 1'b0;
          cnt_d     = '0;
        end
      end
      S_WAIT: begin
        if (ss_s) begin
          state_d    = S_IDLE;
          sel_miso_d = 1'b0;
          sel_mosi_d = 1'b0;
        end else begin
          // A bit clocked with no chunk open is lost; flag it, don't capture it
          if (sclk_rise) overrun_d = 1'b1;
          if (cmd_finish || cmd_next_chunk) begin
            sel_miso_d  = fake_miso_select;
            sel_mosi_d  = fake_mosi_select;
            wbuf_miso_d = fake_miso_data;
            wbuf_mosi_d = fake_mosi_data;
            cnt_d       = '0;
          end
          if (cmd_finish) begin
            state_d = S_FINISH;
          end else if (cmd_next_chunk && next_chunk_size != '0) begin
            state_d     = S_CHUNK;
            size_d      = (next_chunk_size > MAX_SIZE) ? MAX_SIZE : next_chunk_size;
            rbuf_miso_d = '0;
            rbuf_mosi_d = '0;
          end
        end
      end
      S_CHUNK, S_FINISH: begin
        if (ss_s) begin
          state_d    = S_IDLE;
          sel_miso_d = 1'b0;
          sel_mosi_d = 1'b0;
        end else begin
          // Mode 0: the next outgoing bit is presented after each falling edge
          if (sclk_fall) begin
            wbuf_miso_d = {wbuf_miso_q[BUF_SIZE-2:0], 1'b0};
            wbuf_mosi_d = {wbuf_mosi_q[BUF_SIZE-2:0], 1'b0};
          end
          if (sclk_rise && state_q == S_CHUNK) begin
            rbuf_miso_d = {rbuf_miso_q[BUF_SIZE-2:0], miso_s};
            rbuf_mosi_d = {rbuf_mosi_q[BUF_SIZE-2:0], mosi_s};
            cnt_d       = cnt_inc;
            if (cnt_inc == size_q) state_d = S_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_miso_q  <= 1'b0;
      sel_mosi_q  <= 1'b0;
      wbuf_miso_q <= '0;
      wbuf_mosi_q <= '0;
      rbuf_miso_q <= '0;
      rbuf_mosi_q <= '0;
      cnt_q       <= '0;
      size_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_miso_q  <= sel_miso_d;
      sel_mosi_q  <= sel_mosi_d;
      wbuf_miso_q <= wbuf_miso_d;
      wbuf_mosi_q <= wbuf_mosi_d;
      rbuf_miso_q <= rbuf_miso_d;
      rbuf_mosi_q <= rbuf_mosi_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      overrun_q   <= overrun_d;
    end
  end

  // Pass-through is taken straight from the raw pins so no latency is added
  assign mosi_out       = sel_mosi_q ? wbuf_mosi_q[BUF_SIZE-1] : mosi_in;
  assign miso_out       = sel_miso_q ? wbuf_miso_q[BUF_SIZE-1] : miso_in;
  assign comm_active    = (state_q != S_IDLE);
  assign bus_ready      = (state_q == S_WAIT);
  assign real_miso_data = rbuf_miso_q;
  assign real_mosi_data = rbuf_mosi_q;
  assign chunk_overrun  = overrun_q;

endmodule

// File: tb/tb_spi_bus_ctrl.sv
module tb_spi_bus_ctrl;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss_in = 1'b1, sclk_in = 1'b0, mosi_in = 1'b0, miso_in = 1'b0;
  logic       mosi_out, miso_out;
  logic       cmd_next_chunk = 1'b0, cmd_finish = 1'b0;
  logic [3:0] next_chunk_size = '0;
  logic       fake_miso_select = 1'b0, fake_mosi_select = 1'b0;
  logic [8:0] fake_miso_data = '0, fake_mosi_data = '0;
  logic       comm_active, bus_ready, chunk_overrun;
  logic [8:0] real_miso_data, real_mosi_data;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  spi_bus_ctrl #(.BUF_SIZE(9), .CHUNK_SIZE_WIDTH(4), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .rst(rst), .ss_in(ss_in), .sclk_in(sclk_in),
    .mosi_in(mosi_in), .miso_in(miso_in), .mosi_out(mosi_out), .miso_out(miso_out),
    .cmd_next_chunk(cmd_next_chunk), .cmd_finish(cmd_finish),
    .next_chunk_size(next_chunk_size),
    .fake_miso_select(fake_miso_select), .fake_mosi_select(fake_mosi_select),
    .fake_miso_data(fake_miso_data), .fake_mosi_data(fake_mosi_data),
    .comm_active(comm_active), .bus_ready(bus_ready),
    .real_miso_data(real_miso_data), .real_mosi_data(real_mosi_data),
    .chunk_overrun(chunk_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic issue(input logic nxt, input logic fin, input logic [3:0] sz,
                       input logic smi, input logic smo,
                       input logic [8:0] dmi, input logic [8:0] dmo);
    @(negedge sys_clk);
    cmd_next_chunk   = nxt;
    cmd_finish       = fin;
    next_chunk_size  = sz;
    fake_miso_select = smi;
    fake_mosi_select = smo;
    fake_miso_data   = dmi;
    fake_mosi_data   = dmo;
    @(negedge sys_clk);
    cmd_next_chunk = 1'b0;
    cmd_finish     = 1'b0;
  endtask

  // One mode-0 bit: data set while sclk low, outputs sampled just before the rise
  task automatic spi_bit(input logic mo, input logic mi, input logic emo, input logic emi,
                         input string tag);
    mosi_in = mo;
    miso_in = mi;
    wait_cyc(4);
    chk({tag, "_mosi_out"}, mosi_out, emo);
    chk({tag, "_miso_out"}, miso_out, emi);
    sclk_in = 1'b1;
    wait_cyc(4);
    sclk_in = 1'b0;
  endtask

  // n bits, MSB-first from the low n bits of each vector
  task automatic spi_chunk(input int n, input logic [8:0] mo, input logic [8:0] mi,
                           input logic [8:0] emo, input logic [8:0] emi, input string tag);
    for (int i = n - 1; i >= 0; i--)
      spi_bit(mo[i], mi[i], emo[i], emi[i], $sformatf("%s_b%0d", tag, i));
    wait_cyc(4);
  endtask

  initial begin
    // reset state
    wait_cyc(3);
    chk("rst_comm_active", comm_active, 1'b0);
    chk("rst_bus_ready", bus_ready, 1'b0);
    chk("rst_overrun", chunk_overrun, 1'b0);
    chk("rst_real_mosi", real_mosi_data, 9'h000);
    chk("rst_real_miso", real_miso_data, 9'h000);
    mosi_in = 1'b1;
    #1 chk("rst_mosi_pass", mosi_out, 1'b1);
    mosi_in = 1'b0;
    rst = 1'b0;

    // forward: 3-bit chunk, no substitution
    wait_cyc(2);
    ss_in = 1'b0;
    wait_cyc(4);
    chk("fwd_comm_active", comm_active, 1'b1);
    chk("fwd_ready_wait", bus_ready, 1'b1);
    issue(1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 9'h000, 9'h000);
    chk("fwd_ready_busy", bus_ready, 1'b0);
    spi_chunk(3, 9'b110, 9'b011, 9'b110, 9'b011, "fwd");
    chk("fwd_ready_done", bus_ready, 1'b1);
    chk("fwd_real_mosi", real_mosi_data, 9'h006);
    chk("fwd_real_miso", real_miso_data, 9'h003);

    // address chunk of 9 then 8-bit MISO substitution
    issue(1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 9'h000, 9'h000);
    spi_chunk(9, 9'h14D, 9'h000, 9'h14D, 9'h000, "addr");
    chk("addr_real_mosi", real_mosi_data, 9'h14D);
    chk("addr_ready", bus_ready, 1'b1);
    issue(1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 9'h024 << 1, 9'h000);
    spi_chunk(8, 9'h000, 9'h0B3, 9'h000, 9'h024, "sub");
    chk("sub_real_miso", real_miso_data, 9'h0B3);
    chk("sub_real_mosi", real_mosi_data, 9'h000);
    chk("sub_ready", bus_ready, 1'b1);

    // finish with fake MISO, then release ss
    issue(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 9'b110000000, 9'h000);
    chk("fin_ready", bus_ready, 1'b0);
    spi_chunk(4, 9'b1010, 9'b1111, 9'b1010, 9'b1100, "fin");
    chk("fin_ready_after", bus_ready, 1'b0);
    chk("fin_real_miso_held", real_miso_data, 9'h0B3);
    ss_in = 1'b1;
    wait_cyc(3);
    chk("fin_idle_comm", comm_active, 1'b0);
    chk("fin_idle_ready", bus_ready, 1'b0);
    miso_in = 1'b1;
    #1 chk("fin_idle_miso_pass", miso_out, 1'b1);

    // abort after 4 of 9 bits with fake MOSI
    @(negedge sys_clk);
    ss_in = 1'b0;
    wait_cyc(4);
    chk("abt_comm_active", comm_active, 1'b1);
    issue(1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 9'h000, 9'h1FF);
    spi_chunk(4, 9'b1011, 9'h000, 9'b1111, 9'h000, "abt");
    chk("abt_ready_mid", bus_ready, 1'b0);
    ss_in = 1'b1;
    wait_cyc(3);
    chk("abt_comm", comm_active, 1'b0);
    chk("abt_ready", bus_ready, 1'b0);
    chk("abt_real_mosi_held", real_mosi_data, 9'h00B);
    mosi_in = 1'b0;
    #1 chk("abt_mosi_pass", mosi_out, 1'b0);

    // overrun, zero-size chunk, simultaneous commands
    @(negedge sys_clk);
    ss_in = 1'b0;
    wait_cyc(4);
    chk("ovr_clear", chunk_overrun, 1'b0);
    spi_chunk(2, 9'b11, 9'b00, 9'b11, 9'b00, "ovr");
    chk("ovr_set", chunk_overrun, 1'b1);
    chk("ovr_ready", bus_ready, 1'b1);
    chk("ovr_not_captured", real_mosi_data, 9'h00B);
    issue(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 9'h000, 9'h100);
    mosi_in = 1'b0;
    #1 chk("zero_ready", bus_ready, 1'b1);
    chk("zero_sel_updated", mosi_out, 1'b1);
    issue(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 9'h000, 9'h000);
    chk("both_ready", bus_ready, 1'b0);
    spi_chunk(6, 9'b101100, 9'b010011, 9'b101100, 9'b010011, "both");
    chk("both_still_finish", bus_ready, 1'b0);
    chk("both_no_capture", real_mosi_data, 9'h00B);
    chk("both_overrun_sticky", chunk_overrun, 1'b1);
    ss_in = 1'b1;
    wait_cyc(3);
    chk("ovr_idle_sticky", chunk_overrun, 1'b1);
    ss_in = 1'b0;
    wait_cyc(4);
    chk("ovr_cleared_on_ss", chunk_overrun, 1'b0);

    // oversize request is clamped to 9 bits
    issue(1'b1, 1'b0, 4'd15, 1'b0, 1'b0, 9'h000, 9'h000);
    spi_chunk(9, 9'h1A5, 9'h05A, 9'h1A5, 9'h05A, "clamp");
    chk("clamp_ready", bus_ready, 1'b1);
    chk("clamp_real_mosi", real_mosi_data, 9'h1A5);
    chk("clamp_real_miso", real_miso_data, 9'h05A);

    // reset mid-chunk with fake MOSI active
    issue(1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 9'h000, 9'h155);
    spi_bit(1'b1, 1'b0, 1'b1, 1'b0, "rstc_b2");
    spi_bit(1'b1, 1'b0, 1'b0, 1'b0, "rstc_b1");
    spi_bit(1'b1, 1'b0, 1'b1, 1'b0, "rstc_b0");
    wait_cyc(4);
    chk("rstc_real_mosi", real_mosi_data, 9'h007);
    mosi_in = 1'b1;
    #1 chk("rstc_fake_active", mosi_out, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstc_mosi_pass", mosi_out, 1'b1);
    chk("rstc_comm", comm_active, 1'b0);
    chk("rstc_ready", bus_ready, 1'b0);
    chk("rstc_overrun", chunk_overrun, 1'b0);
    chk("rstc_real_mosi_clr", real_mosi_data, 9'h000);
    mosi_in = 1'b0;
    #1 chk("rstc_mosi_pass0", mosi_out, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
